// File: rtl/tt_counter_pkg.sv
// Shared definitions for the tt_updown_counter slice.
//   MODE_WRAP / MODE_SAT : encoding of the sat control input
//   CLAMP_W              : working width of clamp_mod (covers WIDTH up to 16 plus headroom)
//   clamp_mod()          : limits a loaded value to the legal range 0..modulus-1
package tt_counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int unsigned CLAMP_W = 17;

  // Returns value unchanged when in range, otherwise the top of the range.
  function automatic logic [CLAMP_W-1:0] clamp_mod(input logic [CLAMP_W-1:0] value,
                                                   input logic [CLAMP_W-1:0] modulus);
    logic [CLAMP_W-1:0] res;
    res = value;
    if (value >= modulus) begin
      res = modulus - CLAMP_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/tt_updown_counter_if.sv
// Control / status bundle between the TinyTapeout wrapper and tt_updown_counter.
// Optional capture signals exist only when TT_COUNTER_CAPTURE_EN is defined.
//   master : drives clr, load, load_val, en, up, sat, prescale, oe_req (, cap)
//            observes count, tc, out_oe (, cap_val)
//   slave  : the counter side of the same signals
interface tt_updown_counter_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PW    = 4
);

  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up;
  logic             sat;
  logic [PW-1:0]    prescale;
  logic             oe_req;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             out_oe;
`ifdef TT_COUNTER_CAPTURE_EN
  logic             cap;
  logic [WIDTH-1:0] cap_val;
`endif

  modport master (
`ifdef TT_COUNTER_CAPTURE_EN
    output cap,
    input  cap_val,
`endif
    output clr, load, load_val, en, up, sat, prescale, oe_req,
    input  count, tc, out_oe
  );

  modport slave (
`ifdef TT_COUNTER_CAPTURE_EN
    input  cap,
    output cap_val,
`endif
    input  clr, load, load_val, en, up, sat, prescale, oe_req,
    output count, tc, out_oe
  );

endinterface

// File: rtl/tt_prescaler.sv
// Enabled compare counter: emits a tick on every (prescale_i+1)-th enabled cycle.
//   clk, rst_n   : clock, async active-low reset
//   clr_i        : synchronous reset of the internal count (wins over en_i)
//   en_i         : advance the count this cycle
//   prescale_i   : compare value, sampled live so changes apply at the next compare
//   tick_c       : combinational tick, valid for the edge at which it is high
module tt_prescaler #(
  parameter int unsigned PW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [PW-1:0] prescale_i,
  output logic          tick_c
);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;

  // Next count; an overshoot after prescale shrinks returns to 0 without a tick.
  always_comb begin
    pre_d  = pre_q;
    tick_c = 1'b0;
    if (clr_i) begin
      pre_d = '0;
    end else if (en_i) begin
      if (pre_q == prescale_i) begin
        pre_d  = '0;
        tick_c = 1'b1;
      end else if (pre_q > prescale_i) begin
        pre_d = '0;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/tt_updown_counter.sv
// Up/down modulo counter with prescaler, wrap/saturate mode, terminal-count
// pulse and registered output enable. Optional capture register when
// TT_COUNTER_CAPTURE_EN is defined.
//   clk, rst_n : clock, async active-low reset
//   bus        : tt_updown_counter_if.slave
//                in : clr, load, load_val, en, up, sat, prescale, oe_req (, cap)
//                out: count, tc, out_oe (, cap_val) -- all registered
// Parameters: WIDTH (2..16), MODULUS (2..2**WIDTH), PW prescaler width.
module tt_updown_counter
  import tt_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MODULUS = 256,
  parameter int unsigned PW      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  tt_updown_counter_if.slave  bus
);

  // One extra bit so MODULUS = 2**WIDTH has a representable top value.
  localparam int unsigned     CW    = WIDTH + 1;
  localparam logic [CW-1:0]   MAX_C = CW'(MODULUS - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_q;
  logic             tc_d;
  logic             out_oe_q;
  logic             tick_c;
  logic [CW-1:0]    cnt_ext;
  logic [WIDTH-1:0] load_clamped;

  // clr and load both restart the prescaler and suppress a coincident tick.
  tt_prescaler #(
    .PW(PW)
  ) u_prescaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (bus.clr | bus.load),
    .en_i       (bus.en),
    .prescale_i (bus.prescale),
    .tick_c     (tick_c)
  );

  assign load_clamped = WIDTH'(clamp_mod(CLAMP_W'(bus.load_val), CLAMP_W'(MODULUS)));

  // Next count and terminal-count pulse; priority clr > load > tick.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    cnt_ext = {1'b0, count_q};
    if (bus.clr) begin
      count_d = '0;
    end else if (bus.load) begin
      count_d = load_clamped;
    end else if (tick_c) begin
      if (bus.up) begin
        if (cnt_ext < MAX_C) begin
          count_d = WIDTH'(cnt_ext + CW'(1));
        end else begin
          tc_d = 1'b1;
          if (bus.sat != MODE_SAT) begin
            count_d = '0;
          end
        end
      end else begin
        if (cnt_ext != '0) begin
          count_d = WIDTH'(cnt_ext - CW'(1));
        end else begin
          tc_d = 1'b1;
          if (bus.sat != MODE_SAT) begin
            count_d = WIDTH'(MAX_C);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      tc_q     <= 1'b0;
      out_oe_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      tc_q     <= tc_d;
      out_oe_q <= bus.oe_req;
    end
  end

  assign bus.count  = count_q;
  assign bus.tc     = tc_q;
  assign bus.out_oe = out_oe_q;

`ifdef TT_COUNTER_CAPTURE_EN
  logic [WIDTH-1:0] cap_val_q;
  logic [WIDTH-1:0] cap_val_d;

  // Snapshot of the pre-update count; independent of clr/load.
  always_comb begin
    cap_val_d = cap_val_q;
    if (bus.cap) begin
      cap_val_d = count_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_val_q <= '0;
    end else begin
      cap_val_q <= cap_val_d;
    end
  end

  assign bus.cap_val = cap_val_q;
`endif

endmodule

// File: tb/tb_tt_updown_counter.sv
// Directed + short random scoreboard bench for tt_updown_counter (MODULUS=10).
module tb_tt_updown_counter;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned MODULUS = 10;
  localparam int unsigned PW      = 4;

  logic clk;
  logic rst_n;

  tt_updown_counter_if #(.WIDTH(WIDTH), .PW(PW)) bus ();

  tt_updown_counter #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS),
    .PW     (PW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int    cnt;
    bit    tc;
    bit    oe;
    int    cap;
    string tag;
  } exp_t;

  exp_t sb[$];

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state
  int m_cnt = 0;
  int m_pre = 0;
  int m_cap = 0;
  bit m_tc  = 1'b0;
  bit m_oe  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_pre = 0; m_cap = 0; m_tc = 1'b0; m_oe = 1'b0;
  endtask

  // Advance the reference by one edge using the inputs currently driven.
  task automatic model_step();
    int  ps;
    bit  tick;
    ps = int'(bus.prescale);
`ifdef TT_COUNTER_CAPTURE_EN
    if (bus.cap) m_cap = m_cnt;
`endif
    m_oe = bus.oe_req;
    m_tc = 1'b0;
    if (bus.clr) begin
      m_cnt = 0; m_pre = 0;
    end else if (bus.load) begin
      m_cnt = (int'(bus.load_val) > MODULUS - 1) ? MODULUS - 1 : int'(bus.load_val);
      m_pre = 0;
    end else if (bus.en) begin
      tick  = (m_pre == ps);
      m_pre = (m_pre >= ps) ? 0 : m_pre + 1;
      if (tick) begin
        if (bus.up) begin
          if (m_cnt == MODULUS - 1) begin
            m_tc = 1'b1;
            if (!bus.sat) m_cnt = 0;
          end else m_cnt = m_cnt + 1;
        end else begin
          if (m_cnt == 0) begin
            m_tc = 1'b1;
            if (!bus.sat) m_cnt = MODULUS - 1;
          end else m_cnt = m_cnt - 1;
        end
      end
    end
  endtask

  // Push the expectation for the coming edge, clock it, then pop and compare.
  task automatic cycle(input string tag);
    exp_t e;
    model_step();
    e.cnt = m_cnt; e.tc = m_tc; e.oe = m_oe; e.cap = m_cap; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, "/count"}, 32'(bus.count), 32'(e.cnt));
    check({e.tag, "/tc"}, 32'(bus.tc), 32'(e.tc));
    check({e.tag, "/out_oe"}, 32'(bus.out_oe), 32'(e.oe));
`ifdef TT_COUNTER_CAPTURE_EN
    check({e.tag, "/cap_val"}, 32'(bus.cap_val), 32'(e.cap));
`endif
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.clr      = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.en       = 1'b0;
    bus.up       = 1'b1;
    bus.sat      = 1'b0;
    bus.prescale = '0;
    bus.oe_req   = 1'b1;
`ifdef TT_COUNTER_CAPTURE_EN
    bus.cap      = 1'b0;
`endif
    model_reset();

    // Reset state (oe_req high must not leak through while in reset)
    repeat (2) @(posedge clk);
    #1;
    check("reset/count", 32'(bus.count), 32'd0);
    check("reset/tc", 32'(bus.tc), 32'd0);
    check("reset/out_oe", 32'(bus.out_oe), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Wrap-up through the full range, then the tc pulse drops
    bus.en = 1'b1; bus.up = 1'b1; bus.sat = 1'b0; bus.prescale = '0;
    for (int i = 0; i < 12; i++) cycle($sformatf("up_wrap%0d", i));

    // Down at 0 in saturate mode, then wrap mode
    bus.clr = 1'b1; cycle("clr0");
    bus.clr = 1'b0; bus.up = 1'b0; bus.sat = 1'b1;
    for (int i = 0; i < 3; i++) cycle($sformatf("dn_sat%0d", i));
    bus.sat = 1'b0;
    cycle("dn_wrap");
    cycle("dn_after");

    // Saturate at the top
    bus.up = 1'b1; bus.sat = 1'b1;
    for (int i = 0; i < 3; i++) cycle($sformatf("up_sat%0d", i));

    // Prescale 3 from 0, then hold with en low, then resume
    bus.clr = 1'b1; bus.sat = 1'b0; cycle("clr1");
    bus.clr = 1'b0; bus.prescale = PW'(3);
    for (int i = 0; i < 12; i++) cycle($sformatf("ps3_%0d", i));
    for (int i = 0; i < 2; i++) cycle($sformatf("ps3b_%0d", i));
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) cycle($sformatf("hold%0d", i));
    bus.en = 1'b1;
    for (int i = 0; i < 3; i++) cycle($sformatf("resume%0d", i));

    // Shrinking prescale below the running prescaler value
    bus.prescale = PW'(1);
    for (int i = 0; i < 4; i++) cycle($sformatf("ps_shrink%0d", i));

    // Load clamping and load suppressing a tick
    bus.prescale = '0; bus.en = 1'b0;
    bus.load = 1'b1; bus.load_val = 8'd200; cycle("load200");
    bus.en = 1'b1; cycle("load_tick");
    bus.load_val = 8'd3; cycle("load3");
    bus.load = 1'b0; cycle("after_load");

    // clr beats load
    bus.clr = 1'b1; bus.load = 1'b1; bus.load_val = 8'd7; cycle("clr_load");
    bus.clr = 1'b0; bus.load = 1'b0;

    // Count to 5 then async reset between edges
    for (int i = 0; i < 5; i++) cycle($sformatf("to5_%0d", i));
    check("pre_rst/count", 32'(bus.count), 32'd5);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst/count", 32'(bus.count), 32'd0);
    check("async_rst/out_oe", 32'(bus.out_oe), 32'd0);
    check("async_rst/tc", 32'(bus.tc), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.oe_req = 1'b0; cycle("oe_lo");
    bus.oe_req = 1'b1; cycle("oe_hi");

`ifdef TT_COUNTER_CAPTURE_EN
    // Capture at count 7 while counting up
    bus.clr = 1'b1; cycle("cap_clr");
    bus.clr = 1'b0;
    for (int i = 0; i < 7; i++) cycle($sformatf("cap_to7_%0d", i));
    bus.cap = 1'b1; cycle("cap_at7");
    check("cap/count8", 32'(bus.count), 32'd8);
    check("cap/val7", 32'(bus.cap_val), 32'd7);
    bus.cap = 1'b0; cycle("cap_hold");
    bus.clr = 1'b1; cycle("cap_vs_clr");
    bus.clr = 1'b0;
`endif

    // Short random mix
    for (int i = 0; i < 80; i++) begin
      bus.clr      = ($urandom % 16) == 0;
      bus.load     = ($urandom % 10) == 0;
      bus.load_val = WIDTH'($urandom % 16);
      bus.en       = ($urandom % 4) != 0;
      bus.up       = ($urandom % 3) != 0;
      bus.sat      = ($urandom % 2) == 0;
      bus.prescale = PW'($urandom % 3);
      bus.oe_req   = ($urandom % 2) == 0;
`ifdef TT_COUNTER_CAPTURE_EN
      bus.cap      = ($urandom % 5) == 0;
`endif
      cycle($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_updown_counter.md
Name: tt_updown_counter

Overview:
Parametrised successor to the single 8-bit enable/load counter. It is an up/down modulo counter with a programmable prescaler, wrap or saturate mode, a terminal-count pulse, and a registered output with an output-enable flag. It sits behind the TinyTapeout top wrapper: ui_in/uio_in drive the controls, and uo_out/uio_oe carry count and output enable.

Parameters:
WIDTH, 8, counter width in bits (2..16)
MODULUS, 256, count range 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2**WIDTH
PW, 4, prescaler compare width in bits

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear, highest priority
load  input  1  synchronous load of load_val
load_val  input  WIDTH  value to load
en  input  1  count enable
up  input  1  direction: 1 = increment, 0 = decrement
sat  input  1  mode: 1 = saturate at bounds, 0 = wrap
prescale  input  PW  count once every prescale+1 enabled cycles
oe_req  input  1  request to drive the count outward
count  output  WIDTH  registered count value
tc  output  1  one-cycle pulse on terminal-count event
out_oe  output  1  registered output enable, follows oe_req with 1-cycle latency

Behaviour:
- Reset (rst_n low, async): count=0, tc=0, out_oe=0, prescaler=0. Release is synchronous to the next clk edge.
- Priority on each rising clk edge:
  - clr: count=0, prescaler=0, tc=0.
  - else load: count=min(load_val, MODULUS-1), prescaler=0, tc=0.
  - else en: run the prescaler (below).
  - else: hold count and prescaler, tc=0.
- Prescaler, when en=1:
  - If prescaler==prescale: tick, and prescaler returns to 0.
  - Otherwise prescaler+1, no tick.
  - prescale=0 gives a tick every enabled cycle.
  - A change of prescale mid-count is used at the next compare. If prescaler > prescale, it returns to 0 on the next enabled cycle with no tick.
- Tick with up=1:
  - count < MODULUS-1: count+1.
  - count == MODULUS-1 and sat=0: count=0, tc=1.
  - count == MODULUS-1 and sat=1: hold, tc=1 on every such tick.
- Tick with up=0:
  - count > 0: count-1.
  - count == 0 and sat=0: count=MODULUS-1, tc=1.
  - count == 0 and sat=1: hold, tc=1.
- tc is registered, asserted in the same cycle the new count is visible, and is 0 in every non-tick cycle.
- Direction change takes effect on the next tick; no glitch, no extra step.
- All arithmetic is done in WIDTH+1 bits internally, so MODULUS=2**WIDTH wraps correctly.
- out_oe <= oe_req every cycle regardless of clr/load/en. count is always driven; the top wrapper uses out_oe to drive uio_oe, and the block contains no tri-states.
- clr or load in the same cycle as a tick suppresses the tick.

Optional Feature:
Macro TT_COUNTER_CAPTURE_EN.
- Defined: adds input cap (1 bit) and output cap_val (WIDTH bits), reset 0. On a cap edge cycle, cap_val <= count as it was before that edge's update. cap_val is held otherwise and is not affected by clr or load.
- Not defined: ports absent, no capture register.

Decomposition:
- Package tt_counter_pkg holds:
  - the mode encoding constants MODE_WRAP=0 and MODE_SAT=1;
  - a function clamp_mod(value, modulus) used for load clamping.
- One natural sub-module: tt_prescaler (PW-bit compare counter with en and sync reset, emits tick).
- The counter core stays in tt_updown_counter.

Test Plan:
- Reset, then en=1, up=1, sat=0, prescale=0, MODULUS=10: count steps 0..9. Next edge gives count=0 with tc=1 for exactly one cycle.
- up=0, sat=1 from count=0, prescale=0: count holds 0 and tc=1 every cycle. Switch to sat=0: next edge gives count=9, tc=1.
- prescale=3, en=1, up=1 from 0: count increments every 4th cycle (edges 4, 8, 12). Drop en for 5 cycles: count and prescaler hold.
- load=1 with load_val=200 (MODULUS=10): count=9. load together with a tick: count=9, no increment, tc=0.
- clr and load both asserted: count=0. Assert rst_n low mid-count (count=5) between edges: count=0, out_oe=0 immediately.
- With TT_COUNTER_CAPTURE_EN: pulse cap at count=7 while counting up: cap_val=7 while count=8. With oe_req=1: out_oe=1 one cycle later.
